// File: rtl/kbd_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into make/break key events
// and queues them in a small show-ahead FIFO for the consumer to pop.
module kbd_decoder #(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [7:0] din,
   input  logic       din_new,
   output logic [8:0] evt_code,
   output logic       evt_make,
   output logic       evt_valid,
   input  logic       evt_rd,
   output logic       overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX  = '1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE_ST    = 2'd0,
      EXT_ST     = 2'd1,
      BRK_ST     = 2'd2,
      EXT_BRK_ST = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [TW-1:0]   r_tmo;
   logic            w_timeout;

   logic            w_filtered;
   logic            w_is_e0;
   logic            w_is_f0;
   logic            w_fake_shift;

   logic            w_push;
   logic            w_push_ext;
   logic            w_push_make;
   logic [9:0]      w_wr_data;

   logic [9:0]      r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_ovf;
   logic            w_pop;
   logic            w_full;
   logic            w_wr;
   logic            w_drop;
   logic [9:0]      w_head;

   // ------------------------------------------------------------------
   // Byte classification
   // ------------------------------------------------------------------
   assign w_filtered   = (din == 8'h00) || (din == 8'hAA) || (din == 8'hE1) ||
                         (din == 8'hFA) || (din == 8'hFE) || (din == 8'hFF);
   assign w_is_e0      = (din == 8'hE0);
   assign w_is_f0      = (din == 8'hF0);
   assign w_fake_shift = (din == 8'h12) || (din == 8'h59);

   // ------------------------------------------------------------------
   // Prefix FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= IDLE_ST;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A fresh byte always beats the timeout in the same cycle.
   assign w_timeout = (r_state != IDLE_ST) && (r_tmo == TMO_LAST);

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_push_ext   = 1'b0;
      w_push_make  = 1'b1;
      if (din_new) begin
         if (w_filtered) begin
            w_state_next = IDLE_ST;
         end else begin
            case (r_state)
               IDLE_ST: begin
                  if (w_is_e0) begin
                     w_state_next = EXT_ST;
                  end else if (w_is_f0) begin
                     w_state_next = BRK_ST;
                  end else begin
                     w_push = 1'b1;
                  end
               end
               EXT_ST: begin
                  if (w_is_e0) begin
                     w_state_next = EXT_ST;
                  end else if (w_is_f0) begin
                     w_state_next = EXT_BRK_ST;
                  end else if (w_fake_shift) begin
                     w_state_next = IDLE_ST;
                  end else begin
                     w_push       = 1'b1;
                     w_push_ext   = 1'b1;
                     w_state_next = IDLE_ST;
                  end
               end
               BRK_ST: begin
                  if (w_is_f0) begin
                     w_state_next = BRK_ST;
                  end else if (w_is_e0) begin
                     w_state_next = EXT_BRK_ST;
                  end else begin
                     w_push       = 1'b1;
                     w_push_make  = 1'b0;
                     w_state_next = IDLE_ST;
                  end
               end
               EXT_BRK_ST: begin
                  if (w_is_e0 || w_is_f0) begin
                     w_state_next = EXT_BRK_ST;
                  end else if (w_fake_shift) begin
                     w_state_next = IDLE_ST;
                  end else begin
                     w_push       = 1'b1;
                     w_push_ext   = 1'b1;
                     w_push_make  = 1'b0;
                     w_state_next = IDLE_ST;
                  end
               end
               default: w_state_next = IDLE_ST;
            endcase
         end
      end else if (w_timeout) begin
         w_state_next = IDLE_ST;
      end
   end

   // ------------------------------------------------------------------
   // Prefix timeout counter (saturating)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_tmo <= '0;
      end else if (din_new || (r_state == IDLE_ST)) begin
         r_tmo <= '0;
      end else if (r_tmo != TMO_MAX) begin
         r_tmo <= r_tmo + TW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------
   assign w_wr_data = {w_push_make, w_push_ext, din};
   assign w_pop     = evt_rd && (r_count != '0);
   assign w_full    = (r_count == FULL_CNT);
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;

   generate
      for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               r_mem[gi] <= '0;
            end else if (w_wr && (r_wr_ptr == PW'(gi))) begin
               r_mem[gi] <= w_wr_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign w_head    = r_mem[r_rd_ptr];
   assign evt_make  = w_head[9];
   assign evt_code  = w_head[8:0];
   assign evt_valid = (r_count != '0);
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_kbd_decoder.sv
// Bench for kbd_decoder: directed scan-code sequences plus random byte
// streams, each cycle checked against a prefix-flag reference model.
module tb_kbd_decoder;

   localparam int DEPTH = 4;
   localparam int TC    = 16;

   logic       clk     = 1'b0;
   logic       resetN  = 1'b1;
   logic [7:0] din     = 8'h00;
   logic       din_new = 1'b0;
   logic       evt_rd  = 1'b0;
   logic [8:0] evt_code;
   logic       evt_make;
   logic       evt_valid;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   kbd_decoder #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT_CYC(TC)
   ) dut (
      .clk      (clk),
      .resetN   (resetN),
      .din      (din),
      .din_new  (din_new),
      .evt_code (evt_code),
      .evt_make (evt_make),
      .evt_valid(evt_valid),
      .evt_rd   (evt_rd),
      .overflow (overflow)
   );

   // Reference model: pending prefix flags, quiet-cycle count, event queue.
   logic [9:0] m_q[$];
   logic       m_ovf;
   logic       m_ext;
   logic       m_brk;
   int         m_quiet;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf   = 1'b0;
      m_ext   = 1'b0;
      m_brk   = 1'b0;
      m_quiet = 0;
   endtask

   task automatic model_edge(input logic nw, input logic [7:0] b, input logic rd);
      logic       pop;
      logic       push;
      logic [9:0] ev;
      pop  = rd && (m_q.size() > 0);
      push = 1'b0;
      ev   = '0;
      if (nw) begin
         m_quiet = 0;
         if (b inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF}) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
         end else if (b == 8'hE0) begin
            m_ext = 1'b1;
         end else if (b == 8'hF0) begin
            m_brk = 1'b1;
         end else if (m_ext && (b == 8'h12 || b == 8'h59)) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
         end else begin
            push  = 1'b1;
            ev    = {~m_brk, m_ext, b};
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end else if (m_ext || m_brk) begin
         m_quiet++;
         if (m_quiet >= TC) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(ev);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"}, evt_valid, (m_q.size() > 0));
      chk({tag, "_ovf"}, overflow, m_ovf);
      if (m_q.size() > 0) begin
         chk({tag, "_code"}, evt_code, m_q[0][8:0]);
         chk({tag, "_make"}, evt_make, m_q[0][9]);
      end
   endtask

   task automatic cyc(input logic nw, input logic [7:0] b, input logic rd);
      din_new = nw;
      din     = b;
      evt_rd  = rd;
      @(posedge clk);
      model_edge(nw, b, rd);
      #1;
      din_new = 1'b0;
      evt_rd  = 1'b0;
      check_outputs("cyc");
   endtask

   task automatic do_reset();
      resetN  = 1'b0;
      din_new = 1'b0;
      evt_rd  = 1'b0;
      #2;
      model_reset();
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_make", evt_make, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      resetN = 1'b1;
      @(posedge clk);
      model_edge(1'b0, 8'h00, 1'b0);
      #1;
      check_outputs("post_rst");
   endtask

   task automatic expect_head(input string tag, input logic [8:0] code, input logic mk);
      chk({tag, "_v"}, evt_valid, 1);
      chk({tag, "_c"}, evt_code, code);
      chk({tag, "_m"}, evt_make, mk);
   endtask

   initial begin
      logic [7:0] seq1 [5];
      logic [7:0] b;
      int         r;
      seq1 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

      #1;
      do_reset();

      // Make then break of 0x1C
      cyc(1'b1, 8'h1C, 1'b0);
      expect_head("make1c", 9'h01C, 1'b1);
      cyc(1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 8'h1C, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      expect_head("brk1c", 9'h01C, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      chk("empty1", evt_valid, 0);

      // Extended make/break, and fake shift suppression
      cyc(1'b1, 8'hE0, 1'b0); cyc(1'b1, 8'h75, 1'b0);
      cyc(1'b1, 8'hE0, 1'b0); cyc(1'b1, 8'hF0, 1'b0); cyc(1'b1, 8'h75, 1'b0);
      expect_head("ext_make", 9'h175, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      expect_head("ext_brk", 9'h175, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b1, 8'hE0, 1'b0); cyc(1'b1, 8'h12, 1'b0);
      chk("fake_shift", evt_valid, 0);
      cyc(1'b1, 8'hE0, 1'b0); cyc(1'b1, 8'h7C, 1'b0);
      expect_head("prtsc", 9'h17C, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("empty2", evt_valid, 0);

      // Filtered bytes
      cyc(1'b1, 8'hAA, 1'b0); cyc(1'b1, 8'hFA, 1'b0);
      cyc(1'b1, 8'hE0, 1'b0); cyc(1'b1, 8'hFA, 1'b0);
      chk("filtered", evt_valid, 0);
      cyc(1'b1, 8'h1C, 1'b0);
      expect_head("after_filt", 9'h01C, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);

      // Prefix timeout: 20 quiet cycles, then the boundary either side
      cyc(1'b1, 8'hF0, 1'b0);
      repeat (20) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h1C, 1'b0);
      expect_head("tmo20", 9'h01C, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b1, 8'hF0, 1'b0);
      repeat (TC - 1) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h1C, 1'b0);
      expect_head("tmo_edge_brk", 9'h01C, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b1, 8'hF0, 1'b0);
      repeat (TC) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h1C, 1'b0);
      expect_head("tmo_edge_make", 9'h01C, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);

      // Overflow on the fifth push
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, seq1[i], 1'b0);
      chk("ovf_set", overflow, 1);
      for (int i = 0; i < 4; i++) begin
         expect_head("ovf_pop", {1'b0, seq1[i]}, 1'b1);
         cyc(1'b0, 8'h00, 1'b1);
      end
      chk("ovf_empty", evt_valid, 0);

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, seq1[i], 1'b0);
      cyc(1'b1, 8'h1B, 1'b1);
      chk("full_pp_ovf", overflow, 0);
      expect_head("full_pp_h0", 9'h01D, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      expect_head("full_pp_h1", 9'h024, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      expect_head("full_pp_h2", 9'h02D, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      expect_head("full_pp_h3", 9'h01B, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      chk("full_pp_empty", evt_valid, 0);

      // Reset mid-sequence discards queue and prefix
      cyc(1'b1, 8'h16, 1'b0); cyc(1'b1, 8'h1E, 1'b0); cyc(1'b1, 8'hE0, 1'b0);
      do_reset();
      cyc(1'b1, 8'h1C, 1'b0);
      expect_head("post_rst_evt", 9'h01C, 1'b1);
      chk("post_rst_ext", evt_code[8], 0);
      cyc(1'b0, 8'h00, 1'b1);

      // Random byte stream
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 15));
         case (r)
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = 8'h12;
            5:       b = 8'h59;
            6:       b = 8'hFA;
            7:       b = 8'hAA;
            default: b = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 40) == 0) begin
            repeat ($urandom_range(TC - 2, TC + 2)) cyc(1'b0, 8'h00, 1'($urandom_range(0, 3) == 0));
         end
         cyc(1'($urandom_range(0, 2) != 0), b, 1'($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kbd_decoder.md
# kbd_decoder

Decodes the PS/2 scan-code byte stream from the keyboard bit receiver into key events: make/break, with the E0 extended-prefix flag. Completed events go into a small show-ahead FIFO, so game logic can pop one key event per read without tracking prefixes itself. Sits directly downstream of the bit receiver. Its `din`/`din_new` inputs connect to the receiver's `dout`/`dout_new`.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO depth. Must be a power of 2, at least 2.
- `TIMEOUT_CYC`, default 1000000: idle clocks after a prefix byte before the decoder abandons the partial sequence (20 ms at 50 MHz).
- `clk`, input, 1: system clock. Everything is on the rising edge.
- `resetN`, input, 1: asynchronous, active-low reset.
- `din`, input, 8: received scan-code byte. Valid only in the cycle `din_new` is high.
- `din_new`, input, 1: one-cycle strobe marking a new byte.
- `evt_code`, output, 9: head event code. `{ext, code[7:0]}`.
- `evt_make`, output, 1: head event type. 1 = press, 0 = release.
- `evt_valid`, output, 1: FIFO is not empty.
- `evt_rd`, input, 1: pop the head event. Ignored when `evt_valid` = 0.
- `overflow`, output, 1: sticky flag. Set when an event is dropped because the FIFO is full. Cleared only by reset.

## Operation
- The FSM has four states: `IDLE_ST`, `EXT_ST` (E0 seen), `BRK_ST` (F0 seen), `EXT_BRK_ST` (E0 F0 seen).
- Filtered bytes are 0x00, 0xAA, 0xE1, 0xFA, 0xFE, 0xFF. A filtered byte in any state produces no event and the next state is `IDLE_ST`.
- Transitions from `IDLE_ST`:
  - 0xE0 goes to `EXT_ST`.
  - 0xF0 goes to `BRK_ST`.
  - Any other byte pushes `{0,byte}` with make = 1 and stays in `IDLE_ST`.
- Transitions from `EXT_ST`:
  - 0xE0 stays in `EXT_ST`.
  - 0xF0 goes to `EXT_BRK_ST`.
  - 0x12 or 0x59 (fake shift) is dropped and goes to `IDLE_ST`.
  - Any other byte pushes `{1,byte}` with make = 1 and goes to `IDLE_ST`.
- Transitions from `BRK_ST`:
  - 0xF0 stays in `BRK_ST`.
  - 0xE0 goes to `EXT_BRK_ST`.
  - Any other byte pushes `{0,byte}` with make = 0 and goes to `IDLE_ST`.
- Transitions from `EXT_BRK_ST`:
  - 0xE0 or 0xF0 stays in `EXT_BRK_ST`.
  - 0x12 or 0x59 is dropped and goes to `IDLE_ST`.
  - Any other byte pushes `{1,byte}` with make = 0 and goes to `IDLE_ST`.
- Timeout counter:
  - Clears on every `din_new`, and whenever the state is `IDLE_ST`.
  - Otherwise increments by 1 per cycle.
  - When it reaches `TIMEOUT_CYC`-1, the state goes to `IDLE_ST` on the next edge and no event is produced.
  - Its width is clog2(`TIMEOUT_CYC`)+1 bits and it saturates.
- FIFO:
  - Storage is `FIFO_DEPTH` entries of 10 bits each (`{make, ext, code}`).
  - Read and write pointers are clog2(`FIFO_DEPTH`) bits and wrap modulo `FIFO_DEPTH`.
  - The occupancy count is clog2(`FIFO_DEPTH`)+1 bits.
  - `evt_code` and `evt_make` always show the entry at the read pointer.
- Push when full: the event is dropped, `overflow` is set to 1, and the FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Both happen, and the count is unchanged.
  - This also applies when the FIFO is full: the pop frees a slot, so the push is accepted and `overflow` is not set.
  - When the FIFO is empty, the pop is ignored and only the push takes effect.

## Timing
- Reset values:
  - State is `IDLE_ST`.
  - Pointers, count and timeout counter are 0.
  - `evt_valid` is 0, `overflow` is 0, `evt_code` is 9'h000 and `evt_make` is 0. Storage is cleared to 0.
- Latency from byte to event:
  - A `din_new` sampled at edge k updates the state and writes the FIFO at edge k.
  - `evt_valid` is high from just after edge k, i.e. one cycle after the strobe.
- Pop timing:
  - `evt_rd` sampled high at edge k with `evt_valid` = 1 advances the read pointer at edge k.
  - The new head, or `evt_valid` = 0, appears just after edge k.
- Throughput: one byte per cycle is accepted, although PS/2 bytes are roughly 1 ms apart.
- Timeout and `din_new` in the same cycle: `din_new` wins and the byte is decoded in the current state.
- Reset mid-operation:
  - Asserting `resetN` low clears everything immediately, including any partial prefix and queued events.
  - A sequence cut by reset is lost and is never completed by later bytes.

## Test plan
- Byte 0x1C, then 0xF0, 0x1C, no reads → two events: (0x01C, make=1), then (0x01C, make=0). `evt_valid` goes high one cycle after the first strobe.
- Bytes E0 75, then E0 F0 75 → events (0x175, make=1) and (0x175, make=0). Sequence E0 12 E0 7C produces only (0x17C, make=1).
- Bytes 0xAA and 0xFA alone, and 0xE0 followed by 0xFA → no events, state returns to `IDLE_ST`, `evt_valid` stays 0.
- With `TIMEOUT_CYC`=16: byte 0xF0, then 20 quiet cycles, then 0x1C → single event (0x01C, make=1), not a release.
- `FIFO_DEPTH`=4: push 5 make codes 0x15, 0x1D, 0x24, 0x2D, 0x2C with no reads.
  - Required: `overflow` becomes 1, the first 4 codes pop out in order, then `evt_valid` = 0.
  - Then, with the FIFO full, push and pop in the same cycle: count stays 4 and `overflow` is not set again.
- Assert `resetN` after 0xE0 with 2 events queued → all outputs return to 0. Then 0x1C yields (0x01C, make=1) with ext = 0.
